// File: rtl/ahb_sram_subordinate.sv
// AHB-Lite word-wide SRAM subordinate with configurable wait states,
// byte-strobed writes and the standard two-cycle ERROR response.
module ahb_sram_subordinate #(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    DEPTH_WORDS = 4096,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
    parameter int                    WAIT_STATES = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    HSEL,
    input  logic [ADDR_WIDTH-1:0]   HADDR,
    input  logic                    HWRITE,
    input  logic [1:0]              HTRANS,
    input  logic [2:0]              HSIZE,
    input  logic [2:0]              HBURST,
    input  logic [DATA_WIDTH-1:0]   HWDATA,
    input  logic [DATA_WIDTH/8-1:0] HWSTRB,
    input  logic                    HREADY,
    output logic                    HREADYOUT,
    output logic                    HRESP,
    output logic [DATA_WIDTH-1:0]   HRDATA
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [ADDR_WIDTH:0] END_ADDR =
        {1'b0, BASE_ADDR} + (ADDR_WIDTH+1)'(4 * DEPTH_WORDS);
    localparam logic [3:0] WS_LAST = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_XFER,
        S_ERR1,
        S_ERR2
    } state_t;

    logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

    state_t                state, state_next;
    logic [3:0]            count, count_next;
    logic [IDX_W-1:0]      idx_p1, idx_next;
    logic                  write_p1, write_next;
    logic                  accept, can_accept, addr_err;
    logic [ADDR_WIDTH-1:0] offset;
    logic                  unused_ok;

    assign accept   = HSEL && HREADY && HTRANS[1];
    assign offset   = HADDR - BASE_ADDR;
    assign addr_err = (HSIZE != 3'b010) || (HADDR[1:0] != 2'b00) ||
                      (HADDR < BASE_ADDR) || ({1'b0, HADDR} >= END_ADDR);
    assign unused_ok = ^{HBURST, HTRANS[0], offset};

    // Address phase -> data phase control
    always_comb begin
        state_next = state;
        count_next = count;
        idx_next   = idx_p1;
        write_next = write_p1;
        can_accept = 1'b0;
        HREADYOUT  = 1'b1;
        HRESP      = 1'b0;
        case (state)
            S_IDLE: can_accept = 1'b1;
            S_WAIT: begin
                HREADYOUT = 1'b0;
                if (count == WS_LAST) begin
                    state_next = S_XFER;
                    count_next = 4'd0;
                end else begin
                    count_next = count + 4'd1;
                end
            end
            S_XFER: can_accept = 1'b1;
            S_ERR1: begin
                HREADYOUT  = 1'b0;
                HRESP      = 1'b1;
                state_next = S_ERR2;
            end
            S_ERR2: begin
                HRESP      = 1'b1;
                can_accept = 1'b1;
            end
            default: state_next = S_IDLE;
        endcase

        // A beat that is completing (or idle) may overlap the next address phase
        if (can_accept) begin
            state_next = S_IDLE;
            count_next = 4'd0;
            if (accept) begin
                idx_next   = offset[IDX_W+1:2];
                write_next = HWRITE;
                if (addr_err)
                    state_next = S_ERR1;
                else if (WAIT_STATES == 0)
                    state_next = S_XFER;
                else
                    state_next = S_WAIT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            count <= 4'd0;
        end else begin
            state <= state_next;
            count <= count_next;
        end
        idx_p1   <= idx_next;
        write_p1 <= write_next;
    end

    // Data phase: commit strobed bytes at the end of a write beat
    always_ff @(posedge clk) begin
        if (!reset && state == S_XFER && write_p1) begin
            for (int i = 0; i < DATA_WIDTH/8; i++) begin
                if (HWSTRB[i])
                    mem[idx_p1][8*i +: 8] <= HWDATA[8*i +: 8];
            end
        end
    end

    assign HRDATA = (state == S_XFER && !write_p1) ? mem[idx_p1] : '0;

endmodule
